// File: rtl/stream_bus_pkg.sv
// Shared types and the round-robin pick helper for the stream bus receiver.
// rr_pick searches from the slot after 'last', so the previous winner gets the lowest priority.
package stream_bus_pkg;

  localparam int MAX_CHANNELS = 16;

  typedef logic [3:0] chan_id_t;

  // Returns the first set bit of req strictly after 'last', wrapping modulo n.
  // When no bit is set, the result is 'last' and the caller ignores it.
  function automatic chan_id_t rr_pick(logic [15:0] req, chan_id_t last, int n);
    chan_id_t pick;
    bit       found;
    int       idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_CHANNELS; i++) begin
      idx = (int'(last) + i) % n;
      if (i <= n && !found && req[idx[3:0]]) begin
        pick  = chan_id_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Per-channel receive FIFO with a combinational head and an occupancy count.
// The pointers wrap naturally because DEPTH is a power of two.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_en) begin
        rptr <= rptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/stream_bus_recv_mux.sv
// Multi-channel stream receiver: per-channel FIFOs merged round-robin into one
// registered output stream tagged with the source channel.
module stream_bus_recv_mux
  import stream_bus_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [CHANNELS-1:0]                          in_valid,
  input  logic [CHANNELS-1:0][WIDTH-1:0]               in_data,
  output logic [CHANNELS-1:0]                          in_ready,
  input  logic [CHANNELS-1:0]                          chan_en,
  output logic                                         out_valid,
  output logic [WIDTH-1:0]                             out_data,
  output logic [3:0]                                   out_chan,
  input  logic                                         out_ready,
  output logic [CHANNELS-1:0][$clog2(DEPTH+1)-1:0]     fifo_level
);

  logic [CHANNELS-1:0]            fifo_full;
  logic [CHANNELS-1:0]            fifo_empty;
  logic [CHANNELS-1:0]            push;
  logic [CHANNELS-1:0]            pop;
  logic [CHANNELS-1:0]            req;
  logic [CHANNELS-1:0][WIDTH-1:0] head;
  logic [MAX_CHANNELS-1:0]        req_ext;
  logic [WIDTH-1:0]               head_sel;
  chan_id_t                       grant;
  chan_id_t                       rr_ptr;
  logic                           load;
  logic                           any_req;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
    stream_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[c]),
      .wdata (in_data[c]),
      .pop   (pop[c]),
      .rdata (head[c]),
      .level (fifo_level[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  // in_ready comes from FIFO state only, so a full FIFO refuses even while draining.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign req      = ~fifo_empty & chan_en;
  assign any_req  = |req;
  assign load     = !out_valid || out_ready;

  always_comb begin
    req_ext                 = '0;
    req_ext[CHANNELS-1:0]   = req;
    grant                   = rr_pick(req_ext, rr_ptr, CHANNELS);
    head_sel                = '0;
    pop                     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant == chan_id_t'(c)) begin
        head_sel = head[c];
        pop[c]   = load && any_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= chan_id_t'(CHANNELS - 1);
    end else if (load) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= head_sel;
        out_chan  <= grant;
        rr_ptr    <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_bus_recv_mux.sv
// Self-checking bench for stream_bus_recv_mux: fixed vector table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_stream_bus_recv_mux;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int C  = 4;
  localparam int LW = $clog2(D+1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [C-1:0]           in_valid;
  logic [C-1:0][W-1:0]    in_data;
  logic [C-1:0]           in_ready;
  logic [C-1:0]           chan_en;
  logic                   out_valid;
  logic [W-1:0]           out_data;
  logic [3:0]             out_chan;
  logic                   out_ready;
  logic [C-1:0][LW-1:0]   fifo_level;

  stream_bus_recv_mux #(.WIDTH(W), .DEPTH(D), .CHANNELS(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .chan_en    (chan_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_ready  (out_ready),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: one queue per channel plus the output register contents.
  logic [W-1:0] mq [C][$];
  bit           m_ov;
  logic [W-1:0] m_od;
  int           m_oc;
  int           m_rr;

  task automatic model_reset();
    for (int c = 0; c < C; c++) mq[c].delete();
    m_ov = 0;
    m_od = '0;
    m_oc = 0;
    m_rr = C - 1;
  endtask

  task automatic model_step();
    bit [C-1:0] rdy;
    bit         ld;
    int         g;
    int         idx;
    for (int c = 0; c < C; c++) rdy[c] = (mq[c].size() != D);
    ld = !m_ov || out_ready;
    g  = -1;
    for (int k = 1; k <= C; k++) begin
      idx = (m_rr + k) % C;
      if (g < 0 && chan_en[idx] && mq[idx].size() > 0) g = idx;
    end
    if (ld) begin
      if (g >= 0) begin
        m_od = mq[g].pop_front();
        m_ov = 1;
        m_oc = g;
        m_rr = g;
      end else begin
        m_ov = 0;
      end
    end
    for (int c = 0; c < C; c++)
      if (in_valid[c] && rdy[c]) mq[c].push_back(in_data[c]);
  endtask

  task automatic check_model();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      chk("out_data", {24'd0, out_data}, {24'd0, m_od});
      chk("out_chan", {28'd0, out_chan}, m_oc);
    end
    for (int c = 0; c < C; c++) begin
      chk("fifo_level", {29'd0, fifo_level[c]}, mq[c].size());
      chk("in_ready", {31'd0, in_ready[c]}, {31'd0, mq[c].size() != D});
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    in_valid  = '0;
    in_data   = '0;
    chan_en   = '1;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [C-1:0]    iv;
    logic [C*W-1:0]  din;
    logic            ordy;
    logic            eov;
    logic [W-1:0]    edat;
    logic [3:0]      ech;
    logic [C-1:0]    erdy;
    logic [LW-1:0]   elev0;
    logic [LW-1:0]   elev1;
  } vec_t;

  vec_t tbl [10];
  logic [W-1:0] got0 [$];

  initial begin
    // Single beat on ch1, then ch0 filled against a stalled output.
    tbl[0] = '{4'b0010, 32'h0000_A500, 1'b1, 1'b0, 8'h00, 4'd0, 4'b1111, 3'd0, 3'd1};
    tbl[1] = '{4'b0000, 32'h0,         1'b1, 1'b1, 8'hA5, 4'd1, 4'b1111, 3'd0, 3'd0};
    tbl[2] = '{4'b0000, 32'h0,         1'b1, 1'b0, 8'h00, 4'd0, 4'b1111, 3'd0, 3'd0};
    tbl[3] = '{4'b0001, 32'h0000_0010, 1'b0, 1'b0, 8'h00, 4'd0, 4'b1111, 3'd1, 3'd0};
    tbl[4] = '{4'b0001, 32'h0000_0011, 1'b0, 1'b1, 8'h10, 4'd0, 4'b1111, 3'd1, 3'd0};
    tbl[5] = '{4'b0001, 32'h0000_0012, 1'b0, 1'b1, 8'h10, 4'd0, 4'b1111, 3'd2, 3'd0};
    tbl[6] = '{4'b0001, 32'h0000_0013, 1'b0, 1'b1, 8'h10, 4'd0, 4'b1111, 3'd3, 3'd0};
    tbl[7] = '{4'b0001, 32'h0000_0014, 1'b0, 1'b1, 8'h10, 4'd0, 4'b1110, 3'd4, 3'd0};
    tbl[8] = '{4'b0001, 32'h0000_0015, 1'b0, 1'b1, 8'h10, 4'd0, 4'b1110, 3'd4, 3'd0};
    tbl[9] = '{4'b0000, 32'h0,         1'b1, 1'b1, 8'h11, 4'd0, 4'b1111, 3'd3, 3'd0};

    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {24'd0, out_data}, 0);
    chk("rst_out_chan", {28'd0, out_chan}, 0);
    chk("rst_in_ready", {28'd0, in_ready}, 32'hF);
    chk("rst_levels", {20'd0, fifo_level}, 0);

    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].din;
      out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].eov});
      if (tbl[i].eov) begin
        chk($sformatf("vec%0d_out_data", i), {24'd0, out_data}, {24'd0, tbl[i].edat});
        chk($sformatf("vec%0d_out_chan", i), {28'd0, out_chan}, {28'd0, tbl[i].ech});
      end
      chk($sformatf("vec%0d_in_ready", i), {28'd0, in_ready}, {28'd0, tbl[i].erdy});
      chk($sformatf("vec%0d_level0", i), {29'd0, fifo_level[0]}, {29'd0, tbl[i].elev0});
      chk($sformatf("vec%0d_level1", i), {29'd0, fifo_level[1]}, {29'd0, tbl[i].elev1});
    end

    // Reset mid-stream: output holds a beat and ch0 is partly full.
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_levels", {20'd0, fifo_level}, 0);
    chk("midrst_in_ready", {28'd0, in_ready}, 32'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    in_valid   = 4'b1001;
    in_data[0] = 8'h31;
    in_data[3] = 8'h33;
    cycle();
    idle_inputs();
    cycle();
    chk("first_after_rst_chan", {28'd0, out_chan}, 0);
    chk("first_after_rst_data", {24'd0, out_data}, 32'h31);
    repeat (3) cycle();

    // Round-robin: preload 3 beats per channel with arbitration masked.
    chan_en   = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = '1;
      for (int c = 0; c < C; c++) in_data[c] = 8'(c * 16 + k);
      cycle();
    end
    in_valid  = '0;
    chan_en   = '1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("rr_valid", {31'd0, out_valid}, 1);
      chk("rr_chan", {28'd0, out_chan}, i % C);
      chk("rr_data", {24'd0, out_data}, (i % C) * 16 + i / C);
    end
    cycle();
    chk("rr_drained", {31'd0, out_valid}, 0);

    // chan_en: only ch1 enabled, ch0 contents must be held then drained in order.
    chan_en = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      in_valid   = 4'b0011;
      in_data[0] = 8'(8'h40 + k);
      in_data[1] = 8'(8'h50 + k);
      cycle();
      chk("en_only_ch1", {31'd0, out_valid && out_chan != 4'd1}, 0);
    end
    in_valid = '0;
    repeat (4) begin
      cycle();
      chk("en_only_ch1", {31'd0, out_valid && out_chan != 4'd1}, 0);
    end
    chk("en_ch0_retained", {29'd0, fifo_level[0]}, 3);
    chan_en = 4'b0011;
    got0.delete();
    repeat (5) begin
      cycle();
      if (out_valid && out_chan == 4'd0) got0.push_back(out_data);
    end
    chk("en_ch0_count", got0.size(), 3);
    for (int k = 0; k < 3 && k < got0.size(); k++)
      chk("en_ch0_order", {24'd0, got0[k]}, 32'h40 + k);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = C'($urandom);
      in_data   = ($urandom);
      chan_en   = ($urandom_range(0, 3) == 0) ? C'($urandom) : '1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (i >= 600 && i < 800) out_ready = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
